// File: rtl/no_lut_node_if.sv
// -----------------------------------------------------------------------------
// no_lut_node_if
// Bundle between the network controller (master) and one Boolean-network
// node (slave).
//
// Controller -> node:
//   reset_nos   network re-init strobe, loads init_state into both copies
//   init_state  initial node value used on reset_nos
//   start_s0    step request for the slow trajectory copy
//   start_s1    step request for the fast trajectory copy
//   in_s0       regulator values from the slow trajectory, bit i = regulator i
//   in_s1       regulator values from the fast trajectory
//   cfg_we      truth-table write strobe
//   cfg_lut     new truth table, bit k = output for input pattern k
// Node -> controller / neighbours:
//   s0, s1            registered slow / fast copy state
//   node_s0, node_s1  fan-out copies of s0 / s1
//   match             combinational s0 == s1
//   fixed             last fast step produced no change
//   flip_cnt          saturating count of fast-copy value changes
// -----------------------------------------------------------------------------
interface no_lut_node_if #(
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 16
);
    logic                    reset_nos;
    logic                    init_state;
    logic                    start_s0;
    logic                    start_s1;
    logic [NUM_IN-1:0]       in_s0;
    logic [NUM_IN-1:0]       in_s1;
    logic                    cfg_we;
    logic [(1<<NUM_IN)-1:0]  cfg_lut;

    logic                    s0;
    logic                    s1;
    logic                    node_s0;
    logic                    node_s1;
    logic                    match;
    logic                    fixed;
    logic [CNT_W-1:0]        flip_cnt;

    // Controller side: drives strobes, inputs and configuration.
    modport master (
        output reset_nos, init_state, start_s0, start_s1,
               in_s0, in_s1, cfg_we, cfg_lut,
        input  s0, s1, node_s0, node_s1, match, fixed, flip_cnt
    );

    // Node side: consumes strobes, produces its state outputs.
    modport slave (
        input  reset_nos, init_state, start_s0, start_s1,
               in_s0, in_s1, cfg_we, cfg_lut,
        output s0, s1, node_s0, node_s1, match, fixed, flip_cnt
    );
endinterface

// File: rtl/no_lut_node.sv
// -----------------------------------------------------------------------------
// no_lut_node
// Boolean-network node with a run-time-loadable truth table over NUM_IN
// regulator inputs. Two trajectory copies are kept: s0 (slow, steps on every
// second start_s0) and s1 (fast, steps on every start_s1). The fast copy also
// reports per-node fixed-point detection and a saturating flip counter.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (restores the default OR table)
//   bus  no_lut_node_if.slave bundle (strobes, inputs, config, state outputs)
// -----------------------------------------------------------------------------
module no_lut_node #(
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    no_lut_node_if.slave      bus
);

    localparam int LUT_W = 1 << NUM_IN;

    // Default table is the OR of all inputs: only the all-zero pattern gives 0,
    // which reproduces the legacy two-input OR node.
    localparam logic [LUT_W-1:0] LUT_DEFAULT = {{(LUT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [LUT_W-1:0]  r_lut;
    logic              r_s0;
    logic              r_s1;
    logic              r_pass;
    logic              r_fixed;
    logic [CNT_W-1:0]  r_flipCnt;

    logic              w_nextS0;
    logic              w_nextS1;

    // Next values always come from the table currently held; a table written
    // in the same cycle only affects steps from the following cycle onward.
    assign w_nextS0 = r_lut[bus.in_s0];
    assign w_nextS1 = r_lut[bus.in_s1];

    // State update. rst overrides everything including a table write;
    // reset_nos re-initialises the trajectories but leaves the table alone and
    // swallows any start strobes in the same cycle. The slow copy alternates
    // between computing and holding via r_pass, so after reset_nos it updates
    // on the 1st, 3rd, 5th... start_s0, and after rst the first start only arms.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lut     <= LUT_DEFAULT;
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
            r_pass    <= 1'b0;
            r_fixed   <= 1'b0;
            r_flipCnt <= '0;
        end else begin
            if (bus.cfg_we) begin
                r_lut <= bus.cfg_lut;
            end

            if (bus.reset_nos) begin
                r_s0      <= bus.init_state;
                r_s1      <= bus.init_state;
                r_pass    <= 1'b1;
                r_fixed   <= 1'b0;
                r_flipCnt <= '0;
            end else begin
                if (bus.start_s0) begin
                    if (r_pass) begin
                        r_s0   <= w_nextS0;
                        r_pass <= 1'b0;
                    end else begin
                        r_pass <= 1'b1;
                    end
                end

                if (bus.start_s1) begin
                    r_s1    <= w_nextS1;
                    r_fixed <= (w_nextS1 == r_s1);
                    // Count changes but stick at the maximum rather than wrap.
                    if ((w_nextS1 != r_s1) && (r_flipCnt != CNT_MAX)) begin
                        r_flipCnt <= r_flipCnt + CNT_ONE;
                    end
                end
            end
        end
    end

    assign bus.s0       = r_s0;
    assign bus.s1       = r_s1;
    assign bus.node_s0  = r_s0;
    assign bus.node_s1  = r_s1;
    assign bus.match    = (r_s0 == r_s1);
    assign bus.fixed    = r_fixed;
    assign bus.flip_cnt = r_flipCnt;

endmodule

// File: tb/tb_no_lut_node.sv
// -----------------------------------------------------------------------------
// tb_no_lut_node
// Scoreboard bench for no_lut_node. Each driven cycle updates a behavioural
// model of the node and pushes the expected post-edge outputs into a queue;
// an independent monitor pops one entry after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_no_lut_node;

    localparam int NUM_IN  = 4;
    localparam int CNT_W   = 3;
    localparam int LUT_W   = 1 << NUM_IN;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    typedef struct {
        logic             s0;
        logic             s1;
        logic             match;
        logic             fixed;
        logic [CNT_W-1:0] cnt;
    } expT;

    logic clk;
    logic rst;

    no_lut_node_if #(.NUM_IN(NUM_IN), .CNT_W(CNT_W)) bus ();

    no_lut_node #(.NUM_IN(NUM_IN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model state: plain integers and a table value.
    int               mS0, mS1, mPass, mFixed, mCnt;
    logic [LUT_W-1:0] mLut;

    function automatic int lutBit(input logic [LUT_W-1:0] tbl, input int idx);
        return int'((tbl >> idx) & 1);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, advance the model by one
    // rising edge and queue the outputs the node must show after that edge.
    task automatic applyStimulus(
        input bit doRst, input bit nos, input bit init,
        input bit st0, input bit st1,
        input logic [NUM_IN-1:0] in0, input logic [NUM_IN-1:0] in1,
        input bit we, input logic [LUT_W-1:0] lut
    );
        expT e;
        int  n;
        @(negedge clk);
        rst            = doRst;
        bus.reset_nos  = nos;
        bus.init_state = init;
        bus.start_s0   = st0;
        bus.start_s1   = st1;
        bus.in_s0      = in0;
        bus.in_s1      = in1;
        bus.cfg_we     = we;
        bus.cfg_lut    = lut;

        if (doRst) begin
            mS0 = 0; mS1 = 0; mPass = 0; mFixed = 0; mCnt = 0;
            mLut = {{(LUT_W-1){1'b1}}, 1'b0};
        end else begin
            if (nos) begin
                mS0 = int'(init); mS1 = int'(init);
                mPass = 1; mFixed = 0; mCnt = 0;
            end else begin
                if (st0) begin
                    if (mPass == 1) begin
                        mS0 = lutBit(mLut, int'(in0));
                        mPass = 0;
                    end else begin
                        mPass = 1;
                    end
                end
                if (st1) begin
                    n = lutBit(mLut, int'(in1));
                    mFixed = (n == mS1) ? 1 : 0;
                    if (n != mS1) mCnt = (mCnt < CNT_SAT) ? mCnt + 1 : mCnt;
                    mS1 = n;
                end
            end
            if (we) mLut = lut;
        end

        e.s0    = mS0[0];
        e.s1    = mS1[0];
        e.match = (mS0 == mS1);
        e.fixed = mFixed[0];
        e.cnt   = CNT_W'(mCnt);
        expQ.push_back(e);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, '0, '0, 0, '0);
    endtask

    // Monitor: every queued expectation corresponds to one rising edge.
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("s0",       int'(bus.s0),       int'(e.s0));
                checkOutput("s1",       int'(bus.s1),       int'(e.s1));
                checkOutput("node_s0",  int'(bus.node_s0),  int'(e.s0));
                checkOutput("node_s1",  int'(bus.node_s1),  int'(e.s1));
                checkOutput("match",    int'(bus.match),    int'(e.match));
                checkOutput("fixed",    int'(bus.fixed),    int'(e.fixed));
                checkOutput("flip_cnt", int'(bus.flip_cnt), int'(e.cnt));
            end
        end
    end

    initial begin
        logic [NUM_IN-1:0] r0, r1;
        logic [LUT_W-1:0]  rl;
        int                wait_cycles;

        rst = 1'b1;
        bus.reset_nos = 0; bus.init_state = 0; bus.start_s0 = 0; bus.start_s1 = 0;
        bus.in_s0 = '0; bus.in_s1 = '0; bus.cfg_we = 0; bus.cfg_lut = '0;

        $display("[TB] reset and default OR table");
        applyStimulus(1, 0, 0, 0, 0, '0, '0, 0, '0);
        applyStimulus(0, 1, 0, 0, 0, '0, '0, 0, '0);
        applyStimulus(0, 0, 0, 0, 1, '0, 4'b0000, 0, '0);
        applyStimulus(0, 0, 0, 0, 1, '0, 4'b0100, 0, '0);

        $display("[TB] slow cadence");
        applyStimulus(0, 1, 0, 0, 0, '0, '0, 0, '0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 4'b0001, '0, 0, '0);
        applyStimulus(0, 1, 0, 0, 0, '0, '0, 0, '0);
        applyStimulus(0, 0, 0, 1, 0, 4'b0001, '0, 0, '0);
        applyStimulus(0, 0, 0, 1, 0, 4'b0000, '0, 0, '0);
        applyStimulus(0, 0, 0, 1, 0, 4'b0000, '0, 0, '0);

        $display("[TB] table load takes effect next cycle");
        applyStimulus(0, 1, 0, 0, 0, '0, '0, 0, '0);
        applyStimulus(0, 0, 0, 0, 1, '0, 4'hF, 1, 16'h8000);
        applyStimulus(0, 0, 0, 0, 1, '0, 4'h7, 0, '0);
        applyStimulus(0, 0, 0, 0, 1, '0, 4'hF, 0, '0);

        $display("[TB] priority of reset_nos and rst");
        applyStimulus(0, 1, 1, 1, 1, 4'h0, 4'h0, 0, '0);
        applyStimulus(1, 0, 0, 0, 0, '0, '0, 1, 16'h8000);
        applyStimulus(0, 1, 0, 0, 0, '0, '0, 0, '0);
        applyStimulus(0, 0, 0, 0, 1, '0, 4'b0010, 0, '0);

        $display("[TB] flip counter saturation");
        applyStimulus(0, 1, 0, 0, 0, '0, '0, 0, '0);
        for (int i = 0; i < CNT_SAT + 3; i++)
            applyStimulus(0, 0, 0, 0, 1, '0, (i % 2 == 0) ? 4'h1 : 4'h0, 0, '0);

        $display("[TB] match tracking to a fixed point");
        applyStimulus(0, 1, 0, 0, 0, '0, '0, 0, '0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 1, 4'h3, 4'h3, 0, '0);
        idle();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            r0 = NUM_IN'($urandom);
            r1 = NUM_IN'($urandom);
            rl = LUT_W'($urandom);
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 15) == 0),
                          1'($urandom),
                          1'($urandom), 1'($urandom),
                          r0, r1,
                          ($urandom_range(0, 19) == 0), rl);
        end
        idle();

        wait_cycles = 0;
        while (expQ.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/no_lut_node.md
Name: no_lut_node

Overview:
Parametrised Boolean-network node for the GRN attractor engine. It generalises the fixed two-input OR node to NUM_IN regulator inputs, with a run-time-loadable truth table. It keeps two trajectory copies: s0 is the slow copy and steps on every second start_s0, and s1 is the fast copy and steps on every start_s1. It adds per-node fixed-point detection and a saturating flip counter for the fast copy. Instances sit in the generated network array; the network controller drives the start strobes and reset_nos.

Parameters:
NUM_IN, 4, number of regulator inputs (1..6); truth table has 2**NUM_IN entries.
CNT_W, 16, width of the s1 flip counter.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous active-high reset.
reset_nos  in  1  network re-init: load init_state into both copies.
init_state  in  1  initial node value used on reset_nos.
start_s0  in  1  step request for slow copy.
start_s1  in  1  step request for fast copy.
in_s0  in  NUM_IN  regulator values from slow trajectory; bit i = regulator i.
in_s1  in  NUM_IN  regulator values from fast trajectory.
cfg_we  in  1  truth-table write strobe.
cfg_lut  in  2**NUM_IN  new truth table; bit k = output for input pattern k.
s0  out  1  registered slow-copy state.
s1  out  1  registered fast-copy state.
node_s0  out  1  equals s0 (fan-out to neighbours).
node_s1  out  1  equals s1.
match  out  1  combinational (s0 == s1).
fixed  out  1  registered; 1 when the last s1 step produced no change.
flip_cnt  out  CNT_W  registered count of s1 value changes, saturating.

Behaviour:
- Reset (rst=1, highest priority):
  - s0=0, s1=0, pass=0, fixed=0, flip_cnt=0.
  - lut = all ones except bit0=0, i.e. OR of all inputs, matching the legacy node.
- Truth-table index: k = in_sX interpreted as an unsigned integer, with in_sX[0] as the LSB. The next value is lut[k].
- LUT write:
  - When cfg_we=1 and rst=0, lut <= cfg_lut at the clock edge, independent of reset_nos and the starts.
  - A step in the same cycle uses the old lut; the new table takes effect from the next cycle.
- reset_nos=1 (and rst=0): s0 <= init_state, s1 <= init_state, pass <= 1, fixed <= 0, flip_cnt <= 0. Any start strobes in that cycle are ignored.
- Slow copy (start_s0=1, no reset):
  - If pass=1: s0 <= lut[in_s0], pass <= 0.
  - If pass=0: s0 holds, pass <= 1.
  - So after reset_nos, s0 updates on the 1st, 3rd, 5th... start_s0.
  - After rst without reset_nos, pass=0, so the first start_s0 only arms.
- Fast copy (start_s1=1, no reset):
  - s1 <= lut[in_s1].
  - fixed <= (lut[in_s1] == s1).
  - If the value changes, flip_cnt increments, saturating at 2**CNT_W-1 (no wrap).
- No start_s1: s1, fixed and flip_cnt hold.
- start_s0 and start_s1 are independent; both may step in the same cycle.
- Latency: a start at edge N updates the outputs visible after edge N; match follows combinationally.
- Reset mid-operation:
  - rst in any cycle overrides everything, including cfg_we. The LUT returns to the default.
  - reset_nos does not touch the lut.

Test Plan:
1. Default OR, NUM_IN=4: rst; reset_nos with init_state=0; start_s1 with in_s1=4'b0000 -> s1=0, fixed=1, flip_cnt=0. Then in_s1=4'b0100 -> s1=1, fixed=0, flip_cnt=1.
2. Slow cadence: reset_nos; in_s0=4'b0001 held; 4 consecutive start_s0 -> s0 becomes 1 after the 1st; the 2nd holds; the 3rd recomputes; pass toggles 1,0,1,0,1.
3. LUT load: cfg_we with cfg_lut=16'h8000 (AND) in the same cycle as start_s1 and in_s1=4'hF with s1=0 -> s1=1 (old OR table). Next step with in_s1=4'h7 -> s1=0 (new table).
4. Saturation: CNT_W=2; toggle in_s1 between 0 and 1 over 6 steps -> flip_cnt goes 1,2,3,3,3,3.
5. Priority: reset_nos with start_s0=start_s1=1 and init_state=1 -> s0=s1=1, match=1, flip_cnt=0. Asserting rst with cfg_we=1 -> lut returns to the default OR table.
6. Match tracking: run s0/s1 from the same init with identical inputs -> match toggles per the slow/fast cadence; when both settle to a fixed point, match=1 and fixed=1.
